// File: rtl/iram_ctrl.sv
// Instruction-RAM line-fill controller: on a fetch miss, reads one aligned cache line
// from a fixed-latency IRAM and streams the words back to the core.
module iram_ctrl #(
  parameter int PC_SIZE     = 32,
  parameter int WORD_SIZE   = 32,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 i_miss,
  input  logic [PC_SIZE-1:0]   ram_address,
  output logic [WORD_SIZE-1:0] mem_word,
  output logic                 word_ready,
  output logic                 line_last,
  output logic                 busy,
  output logic                 mem_rd_en,
  output logic [PC_SIZE-3:0]   mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [CNT_W-1:0]     fill_count
);

  localparam int AW = PC_SIZE - 2;
  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(LINE_WORDS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, RELEASE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          base_q, base_d;
  logic [CW-1:0]          issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]          rcv_cnt_q, rcv_cnt_d;
  logic [MEM_LATENCY-1:0] pipe_q, pipe_d;
  logic [WORD_SIZE-1:0]   mem_word_q, mem_word_d;
  logic                   word_ready_q, word_ready_d;
  logic                   line_last_q, line_last_d;
  logic                   busy_q, busy_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]          mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]       fill_count_q, fill_count_d;
  logic [AW-1:0]          line_base;
  logic                   accept;
  logic [1:0]             unused_addr_bits;

  // Byte offset within a word is irrelevant to a word-addressed IRAM.
  assign unused_addr_bits = ram_address[1:0];
  assign line_base        = ram_address[PC_SIZE-1:2] & ~LINE_MASK;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    rcv_cnt_d    = rcv_cnt_q;
    mem_word_d   = mem_word_q;
    word_ready_d = 1'b0;
    line_last_d  = 1'b0;
    mem_rd_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    fill_count_d = fill_count_q;

    // Each issued read walks down the pipe and pops out when its data is on mem_rdata.
    pipe_d    = pipe_q << 1;
    pipe_d[0] = mem_rd_en_q;

    // Responses still in flight after an abort are swallowed, not delivered.
    accept = pipe_q[MEM_LATENCY-1] && (state_q != DRAIN);
    if (accept) begin
      mem_word_d   = mem_rdata;
      word_ready_d = 1'b1;
      rcv_cnt_d    = rcv_cnt_q + 1'b1;
      if (rcv_cnt_q == CNT_LAST) begin
        line_last_d = 1'b1;
        if (fill_count_q != {CNT_W{1'b1}}) fill_count_d = fill_count_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_miss) begin
          base_d      = line_base;
          issue_cnt_d = CW'(1);
          rcv_cnt_d   = '0;
          mem_rd_en_d = 1'b1;
          mem_addr_d  = line_base;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!i_miss) begin
          state_d = DRAIN;
        end else if (issue_cnt_q == CNT_FULL) begin
          state_d = COLLECT;
        end else begin
          mem_rd_en_d = 1'b1;
          mem_addr_d  = base_q + AW'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      COLLECT: begin
        if (!i_miss) state_d = DRAIN;
        else if (accept && (rcv_cnt_q == CNT_LAST)) state_d = RELEASE;
      end
      RELEASE: begin
        if (!i_miss) state_d = IDLE;
      end
      DRAIN: begin
        if (pipe_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      issue_cnt_q  <= '0;
      rcv_cnt_q    <= '0;
      pipe_q       <= '0;
      mem_word_q   <= '0;
      word_ready_q <= 1'b0;
      line_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      fill_count_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      issue_cnt_q  <= issue_cnt_d;
      rcv_cnt_q    <= rcv_cnt_d;
      pipe_q       <= pipe_d;
      mem_word_q   <= mem_word_d;
      word_ready_q <= word_ready_d;
      line_last_q  <= line_last_d;
      busy_q       <= busy_d;
      mem_rd_en_q  <= mem_rd_en_d;
      mem_addr_q   <= mem_addr_d;
      fill_count_q <= fill_count_d;
    end
  end

  assign mem_word   = mem_word_q;
  assign word_ready = word_ready_q;
  assign line_last  = line_last_q;
  assign busy       = busy_q;
  assign mem_rd_en  = mem_rd_en_q;
  assign mem_addr   = mem_addr_q;
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// Directed bench for iram_ctrl: line fills, top-of-space, abort, hold in RELEASE,
// reset mid-fill and fill-counter saturation (second instance with a 2-bit counter).
module tb_iram_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_miss = 1'b0;
  logic [31:0] ram_address = '0;
  logic [31:0] mem_rdata;

  logic [31:0] mem_word;
  logic        word_ready, line_last, busy, mem_rd_en;
  logic [29:0] mem_addr;
  logic [15:0] fill_count;

  logic [31:0] s_mem_word;
  logic        s_word_ready, s_line_last, s_busy, s_mem_rd_en;
  logic [29:0] s_mem_addr;
  logic [1:0]  s_fill_count;

  int n_checks = 0;
  int n_fail = 0;
  int fills = 0;

  iram_ctrl #(.PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(4), .MEM_LATENCY(2), .CNT_W(16)) u_dut (
    .clk(clk), .nrst(nrst), .i_miss(i_miss), .ram_address(ram_address),
    .mem_word(mem_word), .word_ready(word_ready), .line_last(line_last), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .fill_count(fill_count)
  );

  iram_ctrl #(.PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(4), .MEM_LATENCY(2), .CNT_W(2)) u_sat (
    .clk(clk), .nrst(nrst), .i_miss(i_miss), .ram_address(ram_address),
    .mem_word(s_mem_word), .word_ready(s_word_ready), .line_last(s_line_last), .busy(s_busy),
    .mem_rd_en(s_mem_rd_en), .mem_addr(s_mem_addr), .mem_rdata(mem_rdata), .fill_count(s_fill_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_0000;
  endfunction

  // IRAM model with a two-cycle read latency; returns junk when no read is due.
  logic [1:0]  p_vld = '0;
  logic [29:0] p_addr0 = '0;
  logic [29:0] p_addr1 = '0;
  always @(posedge clk) begin
    p_vld   <= {p_vld[0], mem_rd_en};
    p_addr0 <= mem_addr;
    p_addr1 <= p_addr0;
  end
  assign mem_rdata = p_vld[1] ? mem_fn(p_addr1) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives a miss and checks every cycle of the fill.
  task automatic do_fill(input logic [31:0] addr, input int hold);
    logic [29:0] base;
    int exp_fc;
    base = addr[31:2] & ~30'h3;
    i_miss = 1'b1;
    ram_address = addr;
    fills++;
    for (int c = 1; c <= 7 + hold; c++) begin
      @(negedge clk);
      check("rd_en", {31'd0, mem_rd_en}, {31'd0, (c <= 4)});
      if (c <= 4) check("mem_addr", {2'b0, mem_addr}, {2'b0, base + 30'(c - 1)});
      check("word_ready", {31'd0, word_ready}, {31'd0, (c >= 4 && c <= 7)});
      if (c >= 4 && c <= 7) check("mem_word", mem_word, mem_fn(base + 30'(c - 4)));
      check("line_last", {31'd0, line_last}, {31'd0, (c == 7)});
      check("busy", {31'd0, busy}, 32'd1);
      exp_fc = (c >= 7) ? fills : fills - 1;
      check("fill_count", {16'd0, fill_count}, 32'(exp_fc));
      check("sat_count", {30'd0, s_fill_count}, 32'((exp_fc > 3) ? 3 : exp_fc));
    end
    i_miss = 1'b0;
    @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("ready_idle", {31'd0, word_ready}, 32'd0);
    $display("fill addr=%h base=%h hold=%0d fill_count=%0d sat=%0d", addr, base, hold, fill_count, s_fill_count);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, word_ready}, 32'd0);
    check("rst_addr", {2'b0, mem_addr}, 32'd0);
    check("rst_word", mem_word, 32'd0);
    check("rst_fill", {16'd0, fill_count}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    $display("reset done");

    do_fill(32'h0000_0104, 0);
    do_fill(32'hFFFF_FFFC, 0);

    // Abort: i_miss drops in cycle 2.
    i_miss = 1'b1;
    ram_address = 32'h0000_0500;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("abort_rd_en", {31'd0, mem_rd_en}, {31'd0, (c <= 2)});
      check("abort_ready", {31'd0, word_ready}, 32'd0);
      check("abort_last", {31'd0, line_last}, 32'd0);
      if (c <= 2) check("abort_busy_hi", {31'd0, busy}, 32'd1);
      if (c >= 5) check("abort_busy_lo", {31'd0, busy}, 32'd0);
      check("abort_fill", {16'd0, fill_count}, 32'(fills));
      if (c == 2) i_miss = 1'b0;
    end
    $display("abort done fill_count=%0d", fill_count);

    // Held in RELEASE for 10 cycles, then one low cycle starts the next fill.
    do_fill(32'h0000_0208, 10);
    do_fill(32'h0000_0300, 0);

    // Reset in cycle 3 of a fill; returning data must be ignored.
    i_miss = 1'b1;
    ram_address = 32'h0000_0600;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 3) check("rfill_rd_en", {31'd0, mem_rd_en}, 32'd1);
      if (c == 3) begin
        nrst = 1'b0;
        i_miss = 1'b0;
      end
      if (c >= 4) begin
        check("rfill_ready", {31'd0, word_ready}, 32'd0);
        check("rfill_busy", {31'd0, busy}, 32'd0);
        check("rfill_rd_en0", {31'd0, mem_rd_en}, 32'd0);
        check("rfill_fill", {16'd0, fill_count}, 32'd0);
      end
      if (c == 4) begin
        check("rfill_addr", {2'b0, mem_addr}, 32'd0);
        check("rfill_word", mem_word, 32'd0);
        check("rfill_last", {31'd0, line_last}, 32'd0);
        check("rfill_sat", {30'd0, s_fill_count}, 32'd0);
        nrst = 1'b1;
      end
    end
    fills = 0;
    $display("reset mid-fill done");

    for (int k = 1; k <= 5; k++) do_fill(32'h0000_1000 * k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iram_ctrl.md
Name: iram_ctrl

Overview:
Instruction-RAM controller that services instruction-cache misses raised by the RISCV core's fetch unit. It accepts a miss request (i_miss plus a byte address) and reads one full cache line from a fixed-latency synchronous instruction memory. Each word is returned to the core as mem_word with a one-cycle word_ready pulse. It sits between the core's miss interface and the backing IRAM.

Parameters:
PC_SIZE, 32, width of ram_address (byte address)
WORD_SIZE, 32, width of one memory word / instruction
LINE_WORDS, 4, words per cache line (power of 2, >=2)
MEM_LATENCY, 2, cycles from mem_rd_en to valid mem_rdata (>=1)
CNT_W, 16, width of the fill performance counter

Ports:
clk  in  1  clock
nrst  in  1  reset
i_miss  in  1  miss request from core; level, held high until line is delivered
ram_address  in  PC_SIZE  byte address of the missing instruction; sampled when a miss is accepted
mem_word  out  WORD_SIZE  returned instruction word
word_ready  out  1  one-cycle pulse: mem_word valid this cycle
line_last  out  1  high together with word_ready on the final word of a line
busy  out  1  controller not in IDLE
mem_rd_en  out  1  read strobe to IRAM
mem_addr  out  PC_SIZE-2  word address to IRAM
mem_rdata  in  WORD_SIZE  IRAM data, valid exactly MEM_LATENCY cycles after the matching mem_rd_en cycle
fill_count  out  CNT_W  number of completed line fills; saturates at all-ones

Behaviour:
- Reset nrst, synchronous, active-low; clock clk. Under reset: state IDLE; mem_word=0, word_ready=0, line_last=0, busy=0, mem_rd_en=0, mem_addr=0, fill_count=0. The in-flight tracking pipe is cleared, so IRAM data returning after reset is ignored.
- All outputs are registered.
- States:
  - IDLE: on i_miss=1, latch base = ram_address[PC_SIZE-1:2] with the low log2(LINE_WORDS) bits cleared; clear the issue and receive counters; go to ISSUE.
  - ISSUE: assert mem_rd_en for exactly LINE_WORDS consecutive cycles, with mem_addr = base+0, base+1, … (ascending; no critical-word-first). When the issue counter reaches LINE_WORDS, deassert mem_rd_en and go to COLLECT.
  - COLLECT: wait until all LINE_WORDS responses have been received, then go to RELEASE.
  - RELEASE: wait for i_miss=0, then go to IDLE. A new miss requires i_miss low for at least one cycle.
  - DRAIN: reached from ISSUE or COLLECT if i_miss=0 (core flush/abort). Stop issuing immediately. Suppress word_ready and line_last for all remaining responses. When the in-flight pipe is empty, go to IDLE. i_miss reasserting during DRAIN is ignored until IDLE.
- Response tracking:
  - A MEM_LATENCY-deep valid shift register records each issued read.
  - When its output is 1 and state is not DRAIN: mem_word<=mem_rdata and word_ready<=1 at the next edge, so word_ready appears MEM_LATENCY+1 cycles after the matching mem_rd_en cycle.
  - line_last is asserted with word_ready when the receive counter equals LINE_WORDS-1.
- Latency: i_miss sampled high at edge 0 gives mem_rd_en in cycles 1..LINE_WORDS. The first word_ready is in cycle MEM_LATENCY+2. Words are delivered back to back, one per cycle, with no bubbles.
- fill_count increments by 1 on each line_last pulse; it holds at 2^CNT_W-1.
- Address arithmetic: the line is aligned, so base+k never carries out of the line. An address in the top line of the space does not wrap.
- i_miss staying high in RELEASE never starts a second fill.
- busy=1 in every state except IDLE.

Test Plan:
- Basic fill (LINE_WORDS=4, MEM_LATENCY=2), i_miss rises with ram_address=0x0000_0104 -> mem_addr 0x40,0x41,0x42,0x43 in cycles 1–4; word_ready in cycles 4–7 carrying the IRAM contents of those addresses; line_last in cycle 7; fill_count=1.
- Top-of-space address ram_address=0xFFFF_FFFC -> mem_addr 0x3FFF_FFFC..0x3FFF_FFFF; no wrap; 4 word_ready pulses.
- Abort: i_miss drops in cycle 2 -> mem_rd_en low from cycle 3; no word_ready at all; busy low once the pipe drains (cycle ≤5); fill_count unchanged.
- i_miss held high for 10 cycles after line_last -> exactly 4 word_ready pulses; the controller stays in RELEASE. i_miss low 1 cycle then high again -> a second fill starts; fill_count=2.
- Reset asserted in cycle 3 of a fill -> all outputs 0 next cycle; stale mem_rdata in cycles 4–5 produces no word_ready.
- Saturation with CNT_W=2 -> run 5 fills; fill_count sequence is 1,2,3,3,3.
